// File: rtl/cic_comp_fir_if.sv
// Sample, coefficient-load and status bundle between the CIC compensation FIR
// and its neighbours (CIC upstream, demod/audio downstream, control).
interface cic_comp_fir_if #(
  parameter int NTAPS      = 16,
  parameter int COEF_WIDTH = 16
);
  localparam int AW = $clog2(NTAPS);

  logic signed [11:0]           d_in;
  logic                         d_clk;
  logic                         coef_we;
  logic [AW-1:0]                coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic signed [11:0]           d_out;
  logic                         d_valid;
  logic                         busy;
  logic                         overrun;
  logic                         sat;

  modport master (
    output d_in, d_clk, coef_we, coef_addr, coef_data,
    input  d_out, d_valid, busy, overrun, sat
  );

  modport slave (
    input  d_in, d_clk, coef_we, coef_addr, coef_data,
    output d_out, d_valid, busy, overrun, sat
  );
endinterface

// File: rtl/cic_comp_fir.sv
// Time-multiplexed single-MAC droop-compensation FIR behind the CIC decimator:
// Q1.14 loadable taps, round-half-up and clamp to 12 bits, one-cycle valid strobe.
module cic_comp_fir #(
  parameter int NTAPS      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic          clk,
  input  logic          reset,
  cic_comp_fir_if.slave bus
);
  localparam int AW = $clog2(NTAPS);
  localparam int PW = 12 + COEF_WIDTH;

  localparam logic [AW-1:0]                LAST_TAP = AW'(NTAPS - 1);
  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(16384);
  localparam logic signed [ACC_WIDTH-1:0]  HALF_LSB = ACC_WIDTH'(8192);
  localparam logic signed [ACC_WIDTH-1:0]  OUT_MAX  = ACC_WIDTH'(2047);
  localparam logic signed [ACC_WIDTH-1:0]  OUT_MIN  = ACC_WIDTH'(-2048);

  typedef enum logic [1:0] {IDLE, MAC, ROUND} state_e;

  state_e                       state_q;
  logic                         d_clk_q;
  logic [AW-1:0]                wr_ptr_q;
  logic [AW-1:0]                newest_q;
  logic [AW-1:0]                tap_q;
  logic signed [11:0]           buf_q  [NTAPS];
  logic signed [COEF_WIDTH-1:0] coef_q [NTAPS];
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [11:0]           rnd_p0;
  logic                         sat_p0;
  logic                         vld_p0;
  logic signed [11:0]           d_out_q;
  logic                         d_valid_q;
  logic                         busy_q;
  logic                         overrun_q;
  logic                         sat_q;

  logic                         cap_edge;
  logic [AW-1:0]                rd_addr;
  logic signed [PW-1:0]         x_ext;
  logic signed [PW-1:0]         c_ext;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  acc_d;

  // Returns {saturated, value}: (a + 2^13) >>> 14 clamped to the 12-bit range.
  function automatic logic [12:0] round_sat(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] r;
    r = (a + HALF_LSB) >>> 14;
    if (r > OUT_MAX)      round_sat = {1'b1, 12'h7FF};
    else if (r < OUT_MIN) round_sat = {1'b1, 12'h800};
    else                  round_sat = {1'b0, r[11:0]};
  endfunction

  always_comb begin
    cap_edge = bus.d_clk & ~d_clk_q;
    rd_addr  = newest_q - tap_q;
    x_ext    = {{COEF_WIDTH{buf_q[rd_addr][11]}}, buf_q[rd_addr]};
    c_ext    = {{12{coef_q[tap_q][COEF_WIDTH-1]}}, coef_q[tap_q]};
    prod     = x_ext * c_ext;
    acc_d    = acc_q + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      d_clk_q   <= 1'b0;
      wr_ptr_q  <= '0;
      newest_q  <= '0;
      tap_q     <= '0;
      vld_p0    <= 1'b0;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      sat_q     <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        buf_q[i]  <= '0;
        coef_q[i] <= '0;
      end
      coef_q[0] <= COEF_ONE;
    end else begin
      d_clk_q <= bus.d_clk;
      vld_p0  <= 1'b0;

      // p0 -> output: rounded result registered onto d_out with a one-cycle strobe
      d_valid_q <= vld_p0;
      if (vld_p0) begin
        d_out_q <= rnd_p0;
        if (sat_p0) sat_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (cap_edge) begin
            buf_q[wr_ptr_q] <= bus.d_in;
            newest_q        <= wr_ptr_q;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
            acc_q           <= '0;
            tap_q           <= '0;
            busy_q          <= 1'b1;
            state_q         <= MAC;
          end else if (bus.coef_we) begin
            coef_q[bus.coef_addr] <= bus.coef_data;
          end
        end
        MAC: begin
          if (cap_edge) overrun_q <= 1'b1;
          acc_q <= acc_d;
          tap_q <= tap_q + AW'(1);
          if (tap_q == LAST_TAP) state_q <= ROUND;
        end
        ROUND: begin
          // acc -> p0: round/clamp; busy drops here so the next sample is accepted
          if (cap_edge) overrun_q <= 1'b1;
          {sat_p0, rnd_p0} <= round_sat(acc_q);
          vld_p0  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.d_out   = d_out_q;
  assign bus.d_valid = d_valid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;
  assign bus.sat     = sat_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Scenario bench for cic_comp_fir: each accepted sample queues its expected
// output and arrival cycle; a negedge monitor checks every d_valid against it.
module tb_cic_comp_fir;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  typedef struct {
    logic signed [11:0] val;
    int                 at;
  } exp_t;
  exp_t sb[$];

  cic_comp_fir_if #(.NTAPS(16), .COEF_WIDTH(16)) bus ();

  cic_comp_fir #(.NTAPS(16), .COEF_WIDTH(16), .ACC_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.d_valid === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got d_out=%0d at cycle %0d, required no output", bus.d_out, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.d_out !== e.val) begin
          fails++;
          $display("FAIL d_out: got %0d, required %0d", bus.d_out, e.val);
        end
        tests++;
        if (cyc !== e.at) begin
          fails++;
          $display("FAIL latency: d_valid at cycle %0d, required cycle %0d", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.d_clk     = 1'b0;
    bus.d_in      = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(addr);
    bus.coef_data = 16'(val);
    @(negedge clk);
    bus.coef_we   = 1'b0;
  endtask

  // One d_clk period of hi+lo cycles; the rise is the capture edge.
  task automatic send(input int s, input int ev, input bit accepted, input int hi, input int lo);
    exp_t e;
    @(negedge clk);
    bus.d_in  = 12'(s);
    bus.d_clk = 1'b1;
    if (accepted) begin
      e.val = 12'(ev);
      e.at  = cyc + 19;
      sb.push_back(e);
    end
    repeat (hi - 1) @(negedge clk);
    bus.d_clk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d outputs missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (bus.d_out   !== 12'sd0) begin fails++; $display("FAIL reset_d_out: got %0d, required 0", bus.d_out); end
    tests++; if (bus.d_valid !== 1'b0)   begin fails++; $display("FAIL reset_d_valid: got %b, required 0", bus.d_valid); end
    tests++; if (bus.busy    !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    tests++; if (bus.overrun !== 1'b0)   begin fails++; $display("FAIL reset_overrun: got %b, required 0", bus.overrun); end
    tests++; if (bus.sat     !== 1'b0)   begin fails++; $display("FAIL reset_sat: got %b, required 0", bus.sat); end
  endtask

  task automatic test_identity();
    int v[4] = '{100, -200, 2047, -2048};
    do_reset();
    foreach (v[i]) send(v[i], v[i], 1'b1, 16, 16);
    wait_drain("identity");
    tests++; if (bus.sat !== 1'b0) begin fails++; $display("FAIL identity_sat: got %b, required 0", bus.sat); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL identity_overrun: got %b, required 0", bus.overrun); end
  endtask

  task automatic test_moving_avg();
    do_reset();
    for (int t = 0; t < 16; t++) write_coef(t, 1024);
    send(2047, 128, 1'b1, 12, 12);
    for (int k = 1; k < 16; k++) send(0, 128, 1'b1, 12, 12);
    send(0, 0, 1'b1, 12, 12);
    send(0, 0, 1'b1, 12, 12);
    wait_drain("moving_avg");
  endtask

  task automatic test_rounding();
    int v[4] = '{3, -3, 1, -1};
    int r[4] = '{2, -1, 1, 0};
    do_reset();
    write_coef(0, 8192);
    foreach (v[i]) send(v[i], r[i], 1'b1, 10, 10);
    wait_drain("rounding");
    tests++; if (bus.sat !== 1'b0) begin fails++; $display("FAIL rounding_sat: got %b, required 0", bus.sat); end
  endtask

  task automatic test_saturation();
    int v[5] = '{2047, 2047, -2048, -2048, -2048};
    int r[5] = '{2047, 2047, 2046, -2, -2048};
    do_reset();
    for (int t = 0; t < 16; t++) write_coef(t, 16384);
    foreach (v[i]) send(v[i], r[i], 1'b1, 12, 12);
    wait_drain("saturation");
    tests++; if (bus.sat !== 1'b1) begin fails++; $display("FAIL saturation_sat: got %b, required 1", bus.sat); end
  endtask

  task automatic test_overrun();
    exp_t e;
    do_reset();
    @(negedge clk);
    bus.d_in  = 12'sd300;
    bus.d_clk = 1'b1;
    e.val = 12'sd300;
    e.at  = cyc + 19;
    sb.push_back(e);
    repeat (4) @(negedge clk);
    bus.d_clk = 1'b0;
    write_coef(0, 0);
    repeat (3) @(negedge clk);
    send(400, 0, 1'b0, 5, 5);
    wait_drain("overrun_first");
    tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL overrun_flag: got %b, required 1", bus.overrun); end
    repeat (10) @(negedge clk);
    send(77, 77, 1'b1, 16, 16);
    wait_drain("overrun_coef_kept");
    tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b, required 1", bus.overrun); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_coef(0, 4096);
    @(negedge clk);
    bus.d_in  = 12'sd1234;
    bus.d_clk = 1'b1;
    repeat (6) @(negedge clk);
    reset     = 1'b1;
    bus.d_clk = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_mid_busy: got %b, required 0", bus.busy); end
    repeat (30) @(negedge clk);
    send(500, 500, 1'b1, 16, 16);
    wait_drain("reset_mid");
  endtask

  initial begin
    reset         = 1'b1;
    bus.d_in      = '0;
    bus.d_clk     = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    test_reset();
    test_identity();
    test_moving_avg();
    test_rounding();
    test_saturation();
    test_overrun();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
